// File: rtl/ls7212_pkg.sv
// Shared definitions for the LS7212 delay-timer front end: bus widths,
// mode encodings and the trigger debounce state machine encoding.
package ls7212_pkg;

    localparam int WB_W_DEFAULT = 8;

    localparam logic [1:0] MODE_ONE_SHOT    = 2'b00;
    localparam logic [1:0] MODE_DLY_OPERATE = 2'b01;
    localparam logic [1:0] MODE_DLY_RELEASE = 2'b10;
    localparam logic [1:0] MODE_DLY_DUAL    = 2'b11;

    // Bit 1 of the encoding is the accepted trigger level.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        QUAL_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        QUAL_LOW    = 2'b11
    } trig_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_reg;
    logic s2_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= d;
            s2_reg <= s1_reg;
        end
    end

    assign q = s2_reg;

endmodule

// File: rtl/trigger_conditioner_ls7212.sv
// Synchronises and debounces the raw trigger pin, emits rise/fall strobes and
// snapshots the weighting and mode bits on every accepted edge.
module trigger_conditioner_ls7212
    import ls7212_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WB_W            = WB_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trigger_raw,
    input  logic [WB_W-1:0] wb_in,
    input  logic            mode_a_in,
    input  logic            mode_b_in,
    output logic            trigger_out,
    output logic            trig_rise,
    output logic            trig_fall,
    output logic [WB_W-1:0] wb_latched,
    output logic [1:0]      mode_latched,
    output logic            cfg_valid
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic            trig_sync;
    trig_state_t     state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            rise_reg, rise_next;
    logic            fall_reg, fall_next;
    logic [WB_W-1:0] wb_reg, wb_next;
    logic [1:0]      mode_reg, mode_next;
    logic            cfg_reg, cfg_next;
    logic            level;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (trigger_raw),
        .q     (trig_sync)
    );

    assign level = (state_reg == STABLE_HIGH) || (state_reg == QUAL_LOW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= STABLE_LOW;
            count_reg <= '0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            wb_reg    <= '0;
            mode_reg  <= 2'b00;
            cfg_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            wb_reg    <= wb_next;
            mode_reg  <= mode_next;
            cfg_reg   <= cfg_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        wb_next    = wb_reg;
        mode_next  = mode_reg;
        cfg_next   = cfg_reg;

        if (trig_sync == level) begin
            // Input agrees with the accepted level: any qualification is abandoned.
            state_next = level ? STABLE_HIGH : STABLE_LOW;
            count_next = '0;
        end else if (count_reg == LAST_COUNT) begin
            state_next = trig_sync ? STABLE_HIGH : STABLE_LOW;
            count_next = '0;
            rise_next  = trig_sync;
            fall_next  = ~trig_sync;
            wb_next    = wb_in;
            mode_next  = {mode_a_in, mode_b_in};
            cfg_next   = 1'b1;
        end else begin
            state_next = trig_sync ? QUAL_HIGH : QUAL_LOW;
            count_next = count_reg + 1'b1;
        end
    end

    assign trigger_out  = level;
    assign trig_rise    = rise_reg;
    assign trig_fall    = fall_reg;
    assign wb_latched   = wb_reg;
    assign mode_latched = mode_reg;
    assign cfg_valid    = cfg_reg;

endmodule
